// File: rtl/merger_tree_loader_pkg.sv
// ============================================================================
// Module : merger_tree_loader_pkg
// Brief  : Shared types, constants and width helpers for the leaf loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package merger_tree_loader_pkg;

    localparam int c_max_data_width = 4096;

    // End-of-run marker; sliced to the instance's DATA_WIDTH.
    localparam logic [c_max_data_width-1:0] c_terminator = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TERM  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int leaf_cnt(input int l);
        return 2 * l;
    endfunction

    function automatic int leaf_w(input int l);
        return (2 * l > 1) ? $clog2(2 * l) : 1;
    endfunction

    function automatic int item_w(input int run_len);
        return (run_len + 1 > 1) ? $clog2(run_len + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/merger_tree_leaf_loader_slot.sv
// ============================================================================
// Module : loader_out_slot
// Brief  : Single-entry output slot with leaf tag, full check and one-hot
//          write decode onto the shared leaf-FIFO data bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module loader_out_slot
    import merger_tree_loader_pkg::*;
#(
    parameter int LEAF_CNT   = 4,
    parameter int LEAF_W     = 2,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [LEAF_W-1:0]     i_load_leaf,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic [LEAF_CNT-1:0]   i_fifo_full,
    output logic [LEAF_CNT-1:0]   o_fifo_write,
    output logic [DATA_WIDTH-1:0] o_fifo_data,
    output logic                  o_free
);

    logic                  r_valid;
    logic [LEAF_W-1:0]     r_leaf;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_leaf_full;
    logic                  w_write;

    // Loop decode keeps non-power-of-two leaf counts in range.
    always_comb begin
        w_leaf_full = 1'b0;
        for (int i = 0; i < LEAF_CNT; i++) begin
            if (r_leaf == LEAF_W'(i)) begin
                w_leaf_full = i_fifo_full[i];
            end
        end
    end

    assign w_write     = r_valid & ~w_leaf_full;
    assign o_free      = ~r_valid | w_write;
    assign o_fifo_data = r_data;

    always_comb begin
        o_fifo_write = '0;
        for (int i = 0; i < LEAF_CNT; i++) begin
            o_fifo_write[i] = w_write & (r_leaf == LEAF_W'(i));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_leaf  <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_leaf  <= i_load_leaf;
            r_data  <= i_load_data;
        end else if (w_write) begin
            r_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/merger_tree_leaf_loader.sv
// ============================================================================
// Module : merger_tree_leaf_loader
// Brief  : Deals a stream of sorted runs round-robin into the 2*L leaf FIFOs.
//          Define MERGER_TREE_LEAF_TERMINATOR_EN to append a zero item per run.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module merger_tree_leaf_loader
    import merger_tree_loader_pkg::*;
#(
    parameter int L          = 32,
    parameter int DATA_WIDTH = 128,
    parameter int RUN_LEN    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [31:0]             i_total_runs,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [2*L-1:0]          i_fifo_full,
    output logic [2*L-1:0]          o_fifo_write,
    output logic [DATA_WIDTH-1:0]   o_fifo_data,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int LEAF_CNT = leaf_cnt(L);
    localparam int LEAF_W   = leaf_w(L);
    localparam int ITEM_W   = item_w(RUN_LEN);
    localparam logic [ITEM_W-1:0] LAST_ITEM = ITEM_W'(RUN_LEN - 1);
    localparam logic [LEAF_W-1:0] LAST_LEAF = LEAF_W'(LEAF_CNT - 1);

    state_t                r_state,    w_state_nxt;
    logic [ITEM_W-1:0]     r_item_cnt, w_item_cnt_nxt;
    logic [LEAF_W-1:0]     r_leaf_ptr, w_leaf_ptr_nxt;
    logic [31:0]           r_run_cnt,  w_run_cnt_nxt;
    logic [31:0]           r_total,    w_total_nxt;

    logic                  w_slot_free;
    logic                  w_slot_load;
    logic [DATA_WIDTH-1:0] w_slot_data;
    logic                  w_accept;
    logic                  w_last_run;
    logic [LEAF_W-1:0]     w_leaf_inc;

    assign o_ready    = (r_state == ST_LOAD) & w_slot_free;
    assign w_accept   = i_valid & o_ready;
    assign w_last_run = (r_run_cnt == r_total - 32'd1);
    assign w_leaf_inc = (r_leaf_ptr == LAST_LEAF) ? '0 : r_leaf_ptr + LEAF_W'(1);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);

    always_comb begin
        w_state_nxt    = r_state;
        w_item_cnt_nxt = r_item_cnt;
        w_leaf_ptr_nxt = r_leaf_ptr;
        w_run_cnt_nxt  = r_run_cnt;
        w_total_nxt    = r_total;
        w_slot_load    = 1'b0;
        w_slot_data    = i_data;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_total_nxt    = i_total_runs;
                    w_item_cnt_nxt = '0;
                    w_leaf_ptr_nxt = '0;
                    w_run_cnt_nxt  = '0;
                    w_state_nxt    = (i_total_runs == 32'd0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_slot_load = 1'b1;
                    if (r_item_cnt == LAST_ITEM) begin
                        w_item_cnt_nxt = '0;
`ifdef MERGER_TREE_LEAF_TERMINATOR_EN
                        w_state_nxt    = ST_TERM;
`else
                        w_leaf_ptr_nxt = w_leaf_inc;
                        w_run_cnt_nxt  = r_run_cnt + 32'd1;
                        if (w_last_run) begin
                            w_state_nxt = ST_DRAIN;
                        end
`endif
                    end else begin
                        w_item_cnt_nxt = r_item_cnt + ITEM_W'(1);
                    end
                end
            end
`ifdef MERGER_TREE_LEAF_TERMINATOR_EN
            ST_TERM: begin
                if (w_slot_free) begin
                    w_slot_load    = 1'b1;
                    w_slot_data    = c_terminator[DATA_WIDTH-1:0];
                    w_leaf_ptr_nxt = w_leaf_inc;
                    w_run_cnt_nxt  = r_run_cnt + 32'd1;
                    w_state_nxt    = w_last_run ? ST_DRAIN : ST_LOAD;
                end
            end
`endif
            // Free means the final entry leaves this cycle, so DONE follows the last write directly.
            ST_DRAIN: begin
                if (w_slot_free) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_item_cnt <= '0;
            r_leaf_ptr <= '0;
            r_run_cnt  <= '0;
            r_total    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_item_cnt <= w_item_cnt_nxt;
            r_leaf_ptr <= w_leaf_ptr_nxt;
            r_run_cnt  <= w_run_cnt_nxt;
            r_total    <= w_total_nxt;
        end
    end

    loader_out_slot #(
        .LEAF_CNT   (LEAF_CNT),
        .LEAF_W     (LEAF_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (w_slot_load),
        .i_load_leaf  (r_leaf_ptr),
        .i_load_data  (w_slot_data),
        .i_fifo_full  (i_fifo_full),
        .o_fifo_write (o_fifo_write),
        .o_fifo_data  (o_fifo_data),
        .o_free       (w_slot_free)
    );

endmodule

`default_nettype wire

// File: tb/tb_merger_tree_leaf_loader.sv
// ============================================================================
// Module : tb_merger_tree_leaf_loader
// Brief  : Self-checking bench; runs are dealt into per-leaf expected queues
//          and compared against the observed leaf writes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_merger_tree_leaf_loader;

    localparam int L        = 2;
    localparam int RUN_LEN  = 4;
    localparam int DW       = 32;
    localparam int LEAF_CNT = 2 * L;
    localparam int LOG_N    = 4096;
`ifdef MERGER_TREE_LEAF_TERMINATOR_EN
    localparam int TERM_EN  = 1;
`else
    localparam int TERM_EN  = 0;
`endif

    logic                clk = 1'b0;
    logic                i_rst = 1'b1;
    logic                i_start = 1'b0;
    logic [31:0]         i_total_runs = '0;
    logic [DW-1:0]       i_data = '0;
    logic                i_valid = 1'b0;
    logic                o_ready;
    logic [LEAF_CNT-1:0] i_fifo_full = '0;
    logic [LEAF_CNT-1:0] o_fifo_write;
    logic [DW-1:0]       o_fifo_data;
    logic                o_busy;
    logic                o_done;

    merger_tree_leaf_loader #(.L(L), .DATA_WIDTH(DW), .RUN_LEN(RUN_LEN)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_total_runs(i_total_runs),
        .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready), .i_fifo_full(i_fifo_full),
        .o_fifo_write(o_fifo_write), .o_fifo_data(o_fifo_data), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] src[$];
    logic [DW-1:0] exp_q[LEAF_CNT][$];
    int            wr_leaf[$];
    logic [DW-1:0] wr_data[$];
    int            wr_cyc[$];
    bit            rdy_log[LOG_N];
    bit            wr_log[LOG_N];
    int            done_cyc, done_cnt, bad_onehot, wr_full, timed_out;
    logic          busy_c1;
    logic          snap_ready, snap_busy, snap_done;
    logic [LEAF_CNT-1:0] snap_wr;
    logic [DW-1:0] snap_data;

    task automatic gen_src(input int total);
        src.delete();
        for (int i = 0; i < total * RUN_LEN; i++) src.push_back(DW'($urandom) | DW'(1));
    endtask

    // Reference: run r belongs to leaf r mod 2L, optionally followed by a zero marker.
    task automatic build_model(input int total);
        for (int l = 0; l < LEAF_CNT; l++) exp_q[l].delete();
        for (int r = 0; r < total; r++) begin
            for (int k = 0; k < RUN_LEN; k++) exp_q[r % LEAF_CNT].push_back(src[r * RUN_LEN + k]);
            if (TERM_EN != 0) exp_q[r % LEAF_CNT].push_back('0);
        end
    endtask

    task automatic drive_load(input int total, input int valid_pct, input int full_leaf,
                              input int full_from, input int full_to, input bit rand_full,
                              input int rst_at, input bit extra_start);
        int si = 0;
        int c  = 0;
        int lf;
        wr_leaf.delete(); wr_data.delete(); wr_cyc.delete();
        done_cyc = -1; done_cnt = 0; bad_onehot = 0; wr_full = 0; timed_out = 0; busy_c1 = 1'b0;
        for (int i = 0; i < LOG_N; i++) begin rdy_log[i] = 1'b0; wr_log[i] = 1'b0; end
        forever begin
            @(negedge clk);
            i_rst        = (c == rst_at);
            i_start      = (c == 0) || (extra_start && c == 3);
            i_total_runs = (c == 0) ? 32'(total) : 32'd1;
            if (rand_full) i_fifo_full = LEAF_CNT'($urandom) & LEAF_CNT'($urandom);
            else i_fifo_full = (c >= full_from && c < full_to) ? (LEAF_CNT'(1) << full_leaf) : '0;
            if (c >= 1 && si < src.size() && $urandom_range(99) < valid_pct) begin
                i_valid = 1'b1; i_data = src[si];
            end else begin
                i_valid = 1'b0; i_data = DW'($urandom);
            end
            #1;
            if (c == rst_at) begin
                snap_ready = o_ready; snap_busy = o_busy; snap_done = o_done;
                snap_wr = o_fifo_write; snap_data = o_fifo_data;
                i_valid = 1'b0; i_start = 1'b0;
                @(negedge clk);
                i_rst = 1'b0;
                break;
            end
            if (c == 1) busy_c1 = o_busy;
            if (i_valid && o_ready) si++;
            if (o_fifo_write != '0) begin
                if (!$onehot(o_fifo_write)) bad_onehot++;
                if ((o_fifo_write & i_fifo_full) != '0) wr_full++;
                lf = 0;
                for (int b = 0; b < LEAF_CNT; b++) if (o_fifo_write[b]) lf = b;
                wr_leaf.push_back(lf); wr_data.push_back(o_fifo_data); wr_cyc.push_back(c);
            end
            rdy_log[c] = o_ready;
            wr_log[c]  = (o_fifo_write != '0);
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
            if (c >= LOG_N - 1) begin timed_out = 1; break; end
            c++;
        end
        i_start = 1'b0; i_valid = 1'b0; i_fifo_full = '0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_assert++;
        if ({o_ready, o_fifo_write, o_fifo_data, o_busy, o_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b wr=%b data=%h busy=%b done=%b, required all 0",
                     o_ready, o_fifo_write, o_fifo_data, o_busy, o_done);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [DW-1:0] e;
        gen_src(4);
        drive_load(4, 100, 0, 0, 0, 1'b0, -1, 1'b0);
        build_model(4);
        n_assert++;
        if (timed_out != 0) begin n_fail++; $display("FAIL basic_timeout: no o_done within %0d cycles", LOG_N); end
        foreach (wr_leaf[i]) begin
            n_assert++;
            if (exp_q[wr_leaf[i]].size() == 0) begin
                n_fail++; $display("FAIL basic_extra_write: leaf %0d got %h, required no write", wr_leaf[i], wr_data[i]);
            end else begin
                e = exp_q[wr_leaf[i]].pop_front();
                if (wr_data[i] !== e) begin
                    n_fail++; $display("FAIL basic_data[%0d]: leaf %0d got %h, required %h", i, wr_leaf[i], wr_data[i], e);
                end
            end
        end
        for (int l = 0; l < LEAF_CNT; l++) begin
            n_assert++;
            if (exp_q[l].size() != 0) begin
                n_fail++; $display("FAIL basic_missing: leaf %0d got %0d items short, required 0", l, exp_q[l].size());
            end
        end
        n_assert++;
        if (wr_leaf.size() != 4 * (RUN_LEN + TERM_EN)) begin
            n_fail++; $display("FAIL basic_write_count: got %0d, required %0d", wr_leaf.size(), 4 * (RUN_LEN + TERM_EN));
        end
        n_assert++;
        if (wr_cyc.size() == 0 || done_cyc != wr_cyc[wr_cyc.size() - 1] + 1) begin
            n_fail++; $display("FAIL basic_done_latency: done at cycle %0d, required last write + 1", done_cyc);
        end
        n_assert++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulse: got %0d cycles, required 1", done_cnt); end
        n_assert++;
        if (busy_c1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, required 1", busy_c1); end
    endtask

    task automatic test_wrap;
        logic [DW-1:0] e;
        int n0 = 0;
        gen_src(6);
        drive_load(6, 100, 0, 0, 0, 1'b0, -1, 1'b0);
        build_model(6);
        foreach (wr_leaf[i]) begin
            n_assert++;
            if (exp_q[wr_leaf[i]].size() == 0) begin
                n_fail++; $display("FAIL wrap_extra_write: leaf %0d got %h, required no write", wr_leaf[i], wr_data[i]);
            end else begin
                e = exp_q[wr_leaf[i]].pop_front();
                if (wr_data[i] !== e) begin
                    n_fail++; $display("FAIL wrap_data[%0d]: leaf %0d got %h, required %h", i, wr_leaf[i], wr_data[i], e);
                end
            end
            if (wr_leaf[i] == 0) n0++;
        end
        for (int l = 0; l < LEAF_CNT; l++) begin
            n_assert++;
            if (exp_q[l].size() != 0) begin
                n_fail++; $display("FAIL wrap_missing: leaf %0d got %0d items short, required 0", l, exp_q[l].size());
            end
        end
        n_assert++;
        if (n0 != 2 * (RUN_LEN + TERM_EN)) begin
            n_fail++; $display("FAIL wrap_leaf0_count: got %0d, required %0d", n0, 2 * (RUN_LEN + TERM_EN));
        end
    endtask

    task automatic test_full_stall;
        logic [DW-1:0] e;
        bit found = 1'b0;
        gen_src(4);
        drive_load(4, 100, 1, 6, 16, 1'b0, -1, 1'b0);
        build_model(4);
        for (int c = 7; c < 16; c++) begin
            n_assert++;
            if (wr_log[c] !== 1'b0 || rdy_log[c] !== 1'b0) begin
                n_fail++; $display("FAIL stall_cycle%0d: got write=%b ready=%b, required 0 0", c, wr_log[c], rdy_log[c]);
            end
        end
        foreach (wr_cyc[i]) if (wr_cyc[i] == 16 && wr_leaf[i] == 1 && wr_data[i] === src[RUN_LEN]) found = 1'b1;
        n_assert++;
        if (!found) begin n_fail++; $display("FAIL stall_resume: got no leaf1 write of %h at cycle 16, required one", src[RUN_LEN]); end
        n_assert++;
        if (wr_full != 0) begin n_fail++; $display("FAIL stall_write_when_full: got %0d, required 0", wr_full); end
        foreach (wr_leaf[i]) begin
            n_assert++;
            if (exp_q[wr_leaf[i]].size() == 0) begin
                n_fail++; $display("FAIL stall_extra_write: leaf %0d got %h, required no write", wr_leaf[i], wr_data[i]);
            end else begin
                e = exp_q[wr_leaf[i]].pop_front();
                if (wr_data[i] !== e) begin
                    n_fail++; $display("FAIL stall_data[%0d]: leaf %0d got %h, required %h", i, wr_leaf[i], wr_data[i], e);
                end
            end
        end
        for (int l = 0; l < LEAF_CNT; l++) begin
            n_assert++;
            if (exp_q[l].size() != 0) begin
                n_fail++; $display("FAIL stall_missing: leaf %0d got %0d items short, required 0", l, exp_q[l].size());
            end
        end
    endtask

    task automatic test_reset_midrun;
        bit saw_leaf2 = 1'b0;
        gen_src(4);
        drive_load(4, 100, 0, 0, 0, 1'b0, 12, 1'b0);
        foreach (wr_leaf[i]) if (wr_leaf[i] == 2) saw_leaf2 = 1'b1;
        n_assert++;
        if (!saw_leaf2) begin n_fail++; $display("FAIL rst_midrun_setup: got no leaf2 write before reset, required one"); end
        n_assert++;
        if ({snap_ready, snap_wr, snap_data, snap_busy, snap_done} !== '0) begin
            n_fail++;
            $display("FAIL rst_midrun_outputs: got rdy=%b wr=%b data=%h busy=%b done=%b, required all 0",
                     snap_ready, snap_wr, snap_data, snap_busy, snap_done);
        end
        gen_src(1);
        drive_load(1, 100, 0, 0, 0, 1'b0, -1, 1'b0);
        n_assert++;
        if (wr_leaf.size() != RUN_LEN + TERM_EN) begin
            n_fail++; $display("FAIL rst_restart_count: got %0d, required %0d", wr_leaf.size(), RUN_LEN + TERM_EN);
        end else begin
            for (int i = 0; i < RUN_LEN; i++) begin
                n_assert++;
                if (wr_leaf[i] != 0 || wr_data[i] !== src[i]) begin
                    n_fail++; $display("FAIL rst_restart[%0d]: got leaf %0d data %h, required leaf 0 data %h",
                                       i, wr_leaf[i], wr_data[i], src[i]);
                end
            end
        end
    endtask

    task automatic test_zero_and_ignored_start;
        logic [DW-1:0] e;
        src.delete();
        drive_load(0, 100, 0, 0, 0, 1'b0, -1, 1'b0);
        n_assert++;
        if (wr_leaf.size() != 0) begin n_fail++; $display("FAIL zero_writes: got %0d, required 0", wr_leaf.size()); end
        n_assert++;
        if (done_cyc < 1 || done_cyc > 2 || done_cnt != 1) begin
            n_fail++; $display("FAIL zero_done: got cycle %0d pulses %0d, required cycle 1..2 pulses 1", done_cyc, done_cnt);
        end
        gen_src(4);
        drive_load(4, 100, 0, 0, 0, 1'b0, -1, 1'b1);
        build_model(4);
        foreach (wr_leaf[i]) begin
            if (exp_q[wr_leaf[i]].size() != 0) begin
                e = exp_q[wr_leaf[i]].pop_front();
                n_assert++;
                if (wr_data[i] !== e) begin
                    n_fail++; $display("FAIL ignored_start_data[%0d]: got %h, required %h", i, wr_data[i], e);
                end
            end
        end
        n_assert++;
        if (wr_leaf.size() != 4 * (RUN_LEN + TERM_EN) || done_cnt != 1) begin
            n_fail++; $display("FAIL ignored_start_count: got %0d writes %0d done, required %0d writes 1 done",
                               wr_leaf.size(), done_cnt, 4 * (RUN_LEN + TERM_EN));
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] e;
        int total;
        for (int t = 0; t < 3; t++) begin
            total = $urandom_range(3, 9);
            gen_src(total);
            drive_load(total, 70, 0, 0, 0, 1'b1, -1, 1'b0);
            build_model(total);
            n_assert++;
            if (timed_out != 0 || done_cnt != 1) begin
                n_fail++; $display("FAIL rand_done: got timeout=%0d pulses=%0d, required 0 1", timed_out, done_cnt);
            end
            n_assert++;
            if (bad_onehot != 0 || wr_full != 0) begin
                n_fail++; $display("FAIL rand_strobe: got onehot_err=%0d write_when_full=%0d, required 0 0", bad_onehot, wr_full);
            end
            foreach (wr_leaf[i]) begin
                n_assert++;
                if (exp_q[wr_leaf[i]].size() == 0) begin
                    n_fail++; $display("FAIL rand_extra_write: leaf %0d got %h, required no write", wr_leaf[i], wr_data[i]);
                end else begin
                    e = exp_q[wr_leaf[i]].pop_front();
                    if (wr_data[i] !== e) begin
                        n_fail++; $display("FAIL rand_data[%0d]: leaf %0d got %h, required %h", i, wr_leaf[i], wr_data[i], e);
                    end
                end
            end
            for (int l = 0; l < LEAF_CNT; l++) begin
                n_assert++;
                if (exp_q[l].size() != 0) begin
                    n_fail++; $display("FAIL rand_missing: leaf %0d got %0d items short, required 0", l, exp_q[l].size());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_full_stall();
        test_reset_midrun();
        test_zero_and_ignored_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
